// File: rtl/fpu_dispatch.sv
// Issue/collect front end for fixed-latency FPU units: reserves each unit's
// writeback cycle in a latency-indexed slot pipeline and returns tagged results.
module fpu_dispatch #(
    parameter int LAT0 = 1,
    parameter int LAT1 = 1,
    parameter int LAT2 = 3,
    parameter int LAT3 = 4
) (
    input  logic        sys_clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_x1,
    input  logic [31:0] req_x2,
    input  logic [4:0]  req_rd,
    output logic [3:0]  unit_valid,
    output logic [31:0] unit_x1,
    output logic [31:0] unit_x2,
    input  logic [31:0] u0_y,
    input  logic [31:0] u1_y,
    input  logic [31:0] u2_y,
    input  logic [31:0] u3_y,
    input  logic [3:0]  u_out_valid,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        proto_err
);

    localparam logic [2:0] L0 = 3'(LAT0);
    localparam logic [2:0] L1 = 3'(LAT1);
    localparam logic [2:0] L2 = 3'(LAT2);
    localparam logic [2:0] L3 = 3'(LAT3);

    // slot[i] describes the unit output expected i-1 cycles from now
    logic [8:1]      busy,  busy_n;
    logic [8:1][1:0] sunit, sunit_n;
    logic [8:1][4:0] srd,   srd_n;
    logic [9:1]      busy_ext;

    logic [2:0]  req_lat;
    logic [3:0]  chk_idx, wr_idx;
    logic        accept;
    logic [3:0]  exp_mask;
    logic        hit, missing, spurious;
    logic [31:0] y_sel;
    logic [3:0]  rel_cnt;

    always_comb begin
        case (req_op)
            2'd0:    req_lat = L0;
            2'd1:    req_lat = L1;
            2'd2:    req_lat = L2;
            default: req_lat = L3;
        endcase
    end

    // slot[9] does not exist; it reads as free so the longest latency is legal
    assign busy_ext  = {1'b0, busy};
    assign chk_idx   = {1'b0, req_lat} + 4'd2;
    assign wr_idx    = {1'b0, req_lat} + 4'd1;
    assign req_ready = rstn & ~busy_ext[chk_idx];
    assign accept    = req_valid & req_ready;

    always_comb begin
        busy_n  = {1'b0, busy[8:2]};
        sunit_n = {2'b00, sunit[8:2]};
        srd_n   = {5'b00000, srd[8:2]};
        if (accept) begin
            busy_n[wr_idx]  = 1'b1;
            sunit_n[wr_idx] = req_op;
            srd_n[wr_idx]   = req_rd;
        end
    end

    always_comb begin
        case (sunit[1])
            2'd0:    y_sel = u0_y;
            2'd1:    y_sel = u1_y;
            2'd2:    y_sel = u2_y;
            default: y_sel = u3_y;
        endcase
    end

    assign exp_mask = busy[1] ? (4'b0001 << sunit[1]) : 4'b0000;
    assign hit      = |(u_out_valid & exp_mask);
    assign missing  = busy[1] & ~hit;
    // stray outputs from operations discarded by reset are ignored for 8 cycles
    assign spurious = rel_cnt[3] & (|(u_out_valid & ~exp_mask));

    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            busy       <= '0;
            sunit      <= '0;
            srd        <= '0;
            unit_valid <= 4'b0000;
            unit_x1    <= 32'h0;
            unit_x2    <= 32'h0;
            wb_valid   <= 1'b0;
            wb_data    <= 32'h0;
            wb_rd      <= 5'h0;
            proto_err  <= 1'b0;
            rel_cnt    <= 4'd0;
        end else begin
            busy       <= busy_n;
            sunit      <= sunit_n;
            srd        <= srd_n;
            unit_valid <= accept ? (4'b0001 << req_op) : 4'b0000;
            if (accept) begin
                unit_x1 <= req_x1;
                unit_x2 <= req_x2;
            end
            wb_valid <= busy[1];
            if (busy[1]) begin
                wb_data <= hit ? y_sel : 32'h0;
                wb_rd   <= srd[1];
            end
            if (missing | spurious) proto_err <= 1'b1;
            if (!rel_cnt[3]) rel_cnt <= rel_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_fpu_dispatch.sv
// Bench for fpu_dispatch: unit models, a completion-cycle reservation model,
// a directed vector table, corner-case sequences and random traffic.
module tb_fpu_dispatch;

    logic        sys_clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [31:0] req_x1 = 32'h0, req_x2 = 32'h0;
    logic [4:0]  req_rd = 5'd0;
    logic [3:0]  unit_valid;
    logic [31:0] unit_x1, unit_x2;
    logic [31:0] uy0 = 32'h0, uy1 = 32'h0, uy2 = 32'h0, uy3 = 32'h0;
    logic [3:0]  u_out_valid = 4'b0;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        proto_err;

    fpu_dispatch dut (
        .sys_clk(sys_clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x1(req_x1), .req_x2(req_x2), .req_rd(req_rd),
        .unit_valid(unit_valid), .unit_x1(unit_x1), .unit_x2(unit_x2),
        .u0_y(uy0), .u1_y(uy1), .u2_y(uy2), .u3_y(uy3),
        .u_out_valid(u_out_valid),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .proto_err(proto_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct { logic [1:0] op; logic [4:0] rd; logic [31:0] data; } wbe_t;
    typedef struct { logic [1:0] op; logic [31:0] x1; logic [31:0] x2; } uve_t;
    typedef struct { int cyc; logic [4:0] rd; logic [31:0] data; } obs_t;
    typedef struct {
        logic [1:0] op; logic [31:0] x1; logic [31:0] x2; logic [4:0] rd;
        logic [31:0] exp_data; int exp_lat;
    } vec_t;

    wbe_t        exp_wb[int];     // keyed by writeback cycle
    uve_t        exp_uv[int];     // keyed by unit_valid cycle
    logic [31:0] u_sched[int];    // unit outputs, keyed by cycle*4+unit
    obs_t        wlog[$];

    int   cyc = 0, nvec = 0, nerr = 0, since = 0, last_cyc = 0;
    logic err_now = 1'b0;
    logic [3:0] drop = 4'b0, spur = 4'b0;
    logic last_acc = 1'b0, last_rdy = 1'b0;

    function automatic int lat_of(input logic [1:0] op);
        case (op)
            2'd0: return 1;
            2'd1: return 1;
            2'd2: return 3;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] ufn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0: return (a == b) ? 32'hffffffff : 32'h0;
            2'd1: return ($signed(a) < $signed(b)) ? 32'hffffffff : 32'h0;
            2'd2: return a + b;
            default: return a * b;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        logic       exp_rdy, ev, acc;
        logic [3:0] m;
        wbe_t       e;
        int         ks[$];
        logic [3:0] ov;
        logic [31:0] yv [4];
        @(negedge sys_clk);
        if (exp_wb.exists(cyc)) begin
            chk("wb_valid", 32'(wb_valid), 32'd1);
            chk("wb_data", wb_data, exp_wb[cyc].data);
            chk("wb_rd", 32'(wb_rd), 32'(exp_wb[cyc].rd));
        end else
            chk("wb_valid", 32'(wb_valid), 32'd0);
        if (exp_uv.exists(cyc)) begin
            chk("unit_valid", 32'(unit_valid), 32'(4'b0001 << exp_uv[cyc].op));
            chk("unit_x1", unit_x1, exp_uv[cyc].x1);
            chk("unit_x2", unit_x2, exp_uv[cyc].x2);
        end else
            chk("unit_valid", 32'(unit_valid), 32'd0);
        exp_rdy = rstn && !exp_wb.exists(cyc + lat_of(req_op) + 2);
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("proto_err", 32'(proto_err), 32'(err_now));
        if (wb_valid === 1'b1) wlog.push_back('{cyc, wb_rd, wb_data});
        last_rdy = req_ready;
        ev = 1'b0;
        if (!rstn) begin
            foreach (exp_wb[k]) if (k > cyc) ks.push_back(k);
            foreach (ks[i]) exp_wb.delete(ks[i]);
            ks.delete();
            foreach (exp_uv[k]) if (k > cyc) ks.push_back(k);
            foreach (ks[i]) exp_uv.delete(ks[i]);
        end else begin
            m = 4'b0;
            if (exp_wb.exists(cyc + 1)) begin
                e = exp_wb[cyc + 1];
                m = 4'b0001 << e.op;
                if (!u_out_valid[e.op]) begin
                    ev = 1'b1;
                    e.data = 32'h0;
                    exp_wb[cyc + 1] = e;
                end
            end
            if (since >= 8 && (u_out_valid & ~m) != 4'b0) ev = 1'b1;
        end
        acc = rstn && req_valid && exp_rdy;
        last_acc = acc;
        last_cyc = cyc;
        if (acc) begin
            exp_wb[cyc + lat_of(req_op) + 2] = '{req_op, req_rd, ufn(req_op, req_x1, req_x2)};
            exp_uv[cyc + 1] = '{req_op, req_x1, req_x2};
        end
        for (int k = 0; k < 4; k++)
            if (unit_valid[k] === 1'b1)
                u_sched[(cyc + lat_of(2'(k))) * 4 + k] = ufn(2'(k), unit_x1, unit_x2);
        err_now = rstn ? (err_now | ev) : 1'b0;
        since = rstn ? since + 1 : 0;
        @(posedge sys_clk);
        #1;
        cyc++;
        ov = 4'b0;
        for (int k = 0; k < 4; k++) begin
            yv[k] = $urandom;
            if (u_sched.exists(cyc * 4 + k)) begin
                if (drop[k]) drop[k] = 1'b0;
                else begin
                    ov[k] = 1'b1;
                    yv[k] = u_sched[cyc * 4 + k];
                end
                u_sched.delete(cyc * 4 + k);
            end
        end
        u_out_valid = ov | spur;
        spur = 4'b0;
        uy0 = yv[0]; uy1 = yv[1]; uy2 = yv[2]; uy3 = yv[3];
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int acyc, output logic first_rdy);
        req_valid = 1'b1; req_op = op; req_x1 = a; req_x2 = b; req_rd = rd;
        acyc = -1;
        first_rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0) first_rdy = last_rdy;
            if (last_acc) begin
                acyc = last_cyc;
                break;
            end
        end
        req_valid = 1'b0;
        if (acyc < 0) begin
            nvec++; nerr++;
            $display("FAIL accept_timeout rd=%0d actual=not_accepted required=accepted", rd);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset(input int n);
        req_valid = 1'b0;
        rstn = 1'b0;
        repeat (n) tick();
        rstn = 1'b1;
    endtask

    function automatic int find_wb(input logic [4:0] rd, input int after, output logic [31:0] d);
        d = 32'hx;
        foreach (wlog[i])
            if (wlog[i].rd == rd && wlog[i].cyc > after) begin
                d = wlog[i].data;
                return wlog[i].cyc;
            end
        return -1;
    endfunction

    initial begin
        vec_t tbl[6];
        int a, a2, a3, c;
        logic r;
        logic [31:0] d;

        tbl[0] = '{2'd0, 32'h3f800000, 32'h3f800000, 5'd5,  32'hffffffff, 3};
        tbl[1] = '{2'd0, 32'h3f800000, 32'h3f800001, 5'd6,  32'h00000000, 3};
        tbl[2] = '{2'd1, 32'h00000001, 32'h00000002, 5'd11, 32'hffffffff, 3};
        tbl[3] = '{2'd2, 32'h00000010, 32'h00000020, 5'd12, 32'h00000030, 5};
        tbl[4] = '{2'd3, 32'h00000003, 32'h00000007, 5'd13, 32'h00000015, 6};
        tbl[5] = '{2'd3, 32'h00010000, 32'h00010000, 5'd31, 32'h00000000, 6};

        @(posedge sys_clk);
        #1;
        cyc = 1;
        tick();
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        tick();
        rstn = 1'b1;
        wait_cyc(10);

        // directed vectors
        foreach (tbl[i]) begin
            issue(tbl[i].op, tbl[i].x1, tbl[i].x2, tbl[i].rd, a, r);
            wait_cyc(tbl[i].exp_lat + 2);
            c = find_wb(tbl[i].rd, a, d);
            chk("tbl_lat", 32'(c - a), 32'(tbl[i].exp_lat));
            chk("tbl_data", d, tbl[i].exp_data);
        end

        // back-to-back feq
        issue(2'd0, 32'h1, 32'h1, 5'd1, a, r);
        issue(2'd0, 32'h1, 32'h2, 5'd2, a2, r);
        issue(2'd0, 32'h7, 32'h7, 5'd3, a3, r);
        chk("b2b_acc2", 32'(a2 - a), 32'd1);
        chk("b2b_acc3", 32'(a3 - a), 32'd2);
        wait_cyc(6);
        chk("b2b_wb1", 32'(find_wb(5'd1, a, d) - a), 32'd3);
        chk("b2b_wb2", 32'(find_wb(5'd2, a, d) - a), 32'd4);
        chk("b2b_wb3", 32'(find_wb(5'd3, a, d) - a), 32'd5);

        // collision: fmul then fadd one cycle later
        issue(2'd3, 32'h2, 32'h5, 5'd7, a, r);
        issue(2'd2, 32'h4, 32'h6, 5'd8, a2, r);
        chk("coll_ready", 32'(r), 32'd0);
        chk("coll_acc", 32'(a2 - a), 32'd2);
        wait_cyc(8);
        chk("coll_wb7", 32'(find_wb(5'd7, a, d) - a), 32'd6);
        chk("coll_wb8", 32'(find_wb(5'd8, a, d) - a), 32'd7);
        chk("coll_data8", d, 32'h0000000a);

        // out-of-order completion
        issue(2'd3, 32'h3, 32'h3, 5'd9, a, r);
        issue(2'd0, 32'h3, 32'h3, 5'd10, a2, r);
        wait_cyc(8);
        chk("ooo_wb10", 32'(find_wb(5'd10, a, d) - a), 32'd4);
        chk("ooo_wb9", 32'(find_wb(5'd9, a, d) - a), 32'd6);
        chk("ooo_data9", d, 32'h9);

        // dropped out_valid on a reserved fadd
        drop = 4'b0100;
        issue(2'd2, 32'h1, 32'h2, 5'd14, a, r);
        wait_cyc(8);
        chk("mm_err", 32'(proto_err), 32'd1);
        c = find_wb(5'd14, a, d);
        chk("mm_wb_cyc", 32'(c - a), 32'd5);
        chk("mm_wb_data", d, 32'h0);
        wait_cyc(3);
        chk("mm_sticky", 32'(proto_err), 32'd1);
        do_reset(2);
        wait_cyc(10);
        chk("mm_cleared", 32'(proto_err), 32'd0);
        spur = 4'b1000;
        wait_cyc(3);
        chk("spur_err", 32'(proto_err), 32'd1);
        do_reset(1);
        wait_cyc(10);

        // reset while an fmul is in flight
        issue(2'd3, 32'h5, 32'h5, 5'd20, a, r);
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        chk("rst_ready", 32'(last_rdy), 32'd1);
        wait_cyc(10);
        chk("rst_no_wb", 32'(find_wb(5'd20, a, d)), 32'hffffffff);
        chk("rst_no_err", 32'(proto_err), 32'd0);

        // random traffic against the reservation model
        req_valid = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (!req_valid || last_acc) begin
                if ($urandom_range(0, 9) < 7) begin
                    req_valid = 1'b1;
                    req_op = 2'($urandom_range(0, 3));
                    req_x1 = $urandom;
                    req_x2 = ($urandom_range(0, 1) == 1) ? req_x1 : $urandom;
                    req_rd = 5'($urandom_range(0, 31));
                end else
                    req_valid = 1'b0;
            end
            tick();
        end
        req_valid = 1'b0;
        wait_cyc(10);
        chk("final_err", 32'(proto_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
